// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM-stage bus initiator.
package mem_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  localparam int          TIMEOUT_DEF  = 16;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

  function automatic int ctr_w(input int timeout);
    return $clog2(timeout) + 1;
  endfunction
endpackage

// File: rtl/mem_timeout_ctr.sv
// Clear/enable cycle counter; expired flags the last allowed REQ/WAIT cycle.
module mem_timeout_ctr
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = ctr_w(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!resetn)  cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: valid/ready request, waits for response,
// stalls the pipeline and presents mdo for one done cycle.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int          TIMEOUT  = TIMEOUT_DEF,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mwmem,
  input  logic        mm2reg,
  input  logic [31:0] mr,
  input  logic [31:0] mqb,
  output logic        stall,
  output logic [31:0] mdo,
  output logic        done,
  output logic        err,
  output logic        req_valid,
  output logic        req_we,
  output logic [29:0] req_addr,
  output logic [31:0] req_wdata,
  input  logic        req_ready,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata
);
  state_t   state, state_nx;
  mem_req_t rq;
  logic     acc, misal, busy, accept, complete, expired, tmo;

  assign acc      = mwmem | mm2reg;
  assign misal    = |mr[1:0];
  assign busy     = (state == REQ) | (state == WAIT);
  assign accept   = (state == REQ) & req_valid & req_ready;
  assign complete = (accept & rsp_valid) | ((state == WAIT) & rsp_valid);
  // A response arriving on the last allowed cycle beats the timeout.
  assign tmo      = busy & expired & ~complete;

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .resetn  (resetn),
    .clr     (state == IDLE),
    .en      (busy),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (acc) state_nx = misal ? DONE : REQ;
      REQ: begin
        if (complete | tmo) state_nx = DONE;
        else if (accept)    state_nx = WAIT;
      end
      WAIT: if (complete | tmo) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall = ((state == IDLE) & acc) | busy;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rq        <= '0;
      req_valid <= 1'b0;
      mdo       <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (acc) begin
          if (misal) begin
            done <= 1'b1;
            err  <= 1'b1;
            mdo  <= '0;
          end else begin
            rq        <= '{we: mwmem, addr: mr[31:2], wdata: mqb};
            req_valid <= 1'b1;
          end
        end
        REQ, WAIT: begin
          if (accept) req_valid <= 1'b0;
          if (complete) begin
            done <= 1'b1;
            if (!rq.we) mdo <= rsp_rdata;
          end else if (tmo) begin
            req_valid <= 1'b0;
            done      <= 1'b1;
            err       <= 1'b1;
            mdo       <= ERR_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_we    = rq.we;
  assign req_addr  = rq.addr;
  assign req_wdata = rq.wdata;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a scripted memory responder.
module tb_mem_access_unit;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        resetn, mwmem, mm2reg, req_ready, rsp_valid;
  logic [31:0] mr, mqb, rsp_rdata;
  logic        stall, done, err, req_valid, req_we;
  logic [31:0] mdo, req_wdata;
  logic [29:0] req_addr;

  typedef struct packed { logic err; logic [31:0] mdo; } exp_t;
  exp_t        sb[$];
  logic [31:0] model_mdo;
  int          n_chk = 0, n_fail = 0;

  mem_access_unit #(.TIMEOUT(TMO), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .resetn(resetn), .mwmem(mwmem), .mm2reg(mm2reg), .mr(mr), .mqb(mqb),
    .stall(stall), .mdo(mdo), .done(done), .err(err),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One MEM-stage access; ready comes rdly REQ cycles late, rsp gap cycles after accept.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int rdly, input int gap, input logic [31:0] rdata);
    exp_t e;
    int   exp_stall, exp_reqc, stall_c, reqc, wc;
    bit   mis, tmo, accepted, got;
    logic rr, rv;
    mis = (addr[1:0] != 2'b00);
    tmo = !mis && (rdly + gap > TMO - 1);
    if (mis)      begin e.err = 1'b1; e.mdo = 32'h0;        exp_stall = 1;       exp_reqc = 0; end
    else if (tmo) begin e.err = 1'b1; e.mdo = 32'hDEADBEEF; exp_stall = 1 + TMO; exp_reqc = (rdly >= TMO) ? TMO : rdly + 1; end
    else begin
      e.err = 1'b0; e.mdo = we ? model_mdo : rdata;
      exp_stall = 2 + rdly + gap; exp_reqc = rdly + 1;
    end
    model_mdo = e.mdo;
    sb.push_back(e);
    mwmem = we; mm2reg = !we; mr = addr; mqb = wdata; rsp_rdata = rdata;
    stall_c = 0; reqc = 0; wc = 0; accepted = 0; got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      #1;
      if (c == 0) chk("done_low_at_start", done, 0);
      if (done) begin
        exp_t x;
        got = 1;
        chk("stall_in_done", stall, 0);
        chk("stall_cycles", stall_c, exp_stall);
        chk("req_cycles", reqc, exp_reqc);
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          x = sb.pop_front();
          chk("mdo", mdo, x.mdo);
          chk("err", err, x.err);
        end
        mwmem = 0; mm2reg = 0; req_ready = 0; rsp_valid = 0;
      end else begin
        if (stall) stall_c++;
        if (req_valid) begin
          reqc++;
          chk("req_addr", req_addr, addr[31:2]);
          chk("req_we", req_we, we);
          chk("req_wdata", req_wdata, wdata);
        end
        rr = req_valid && !accepted && (reqc - 1 >= rdly);
        rv = rr && (gap == 0);
        if (accepted) begin wc++; if (wc == gap) rv = 1; end
        if (rr) accepted = 1;
        req_ready = rr; rsp_valid = rv;
      end
      @(negedge clk);
    end
    if (!got) begin
      chk("done_within_bound", 0, 1);
      if (sb.size() != 0) void'(sb.pop_front());
      mwmem = 0; mm2reg = 0; req_ready = 0; rsp_valid = 0;
    end
  endtask

  initial begin
    resetn = 0; mwmem = 0; mm2reg = 0; mr = 0; mqb = 0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = 0; model_mdo = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_mdo", mdo, 0);
    chk("rst_stall", stall, 0);
    chk("rst_req_addr", req_addr, 0);
    chk("rst_req_we", req_we, 0);
    resetn = 1;
    @(negedge clk);

    access(1'b0, 32'h10, 32'h0, 0, 0, 32'h40000044);          // fastest load
    access(1'b1, 32'h20, 32'h12345678, 2, 1, 32'h55555555);   // store, late ready
    access(1'b0, 32'h13, 32'h0, 0, 0, 32'h77777777);          // misaligned
    access(1'b0, 32'h40, 32'h0, 99, 0, 32'h66666666);         // never ready -> timeout
    access(1'b0, 32'h44, 32'h0, 15, 0, 32'hCAFEF00D);         // completes on last cycle
    access(1'b0, 32'h48, 32'h0, 14, 1, 32'h0BADF00D);         // completes in WAIT, last cycle
    access(1'b0, 32'h0,  32'h0, 0, 0, 32'hA00000AA);          // back-to-back loads
    access(1'b0, 32'h4,  32'h0, 0, 0, 32'h10000011);

    // Reset while in WAIT; a late response must not complete anything.
    mm2reg = 1; mr = 32'h80; rsp_rdata = 32'hBAADBAAD;
    @(negedge clk);               // REQ
    req_ready = 1;
    @(negedge clk);               // WAIT
    req_ready = 0; mm2reg = 0; resetn = 0;
    @(negedge clk);
    #1;
    chk("wrst_req_valid", req_valid, 0);
    chk("wrst_stall", stall, 0);
    chk("wrst_mdo", mdo, 0);
    resetn = 1; rsp_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("late_rsp_no_done", done, 0);
      chk("late_rsp_no_stall", stall, 0);
    end
    rsp_valid = 0;
    model_mdo = 0;
    @(negedge clk);
    access(1'b0, 32'h8, 32'h0, 1, 2, 32'h13579BDF);           // recovers after reset

    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage bus initiator. It takes the load/store request of the instruction in MEM (mwmem, mm2reg, mr, mqb) and drives a valid/ready request + response handshake toward a variable-latency data memory responder.
- It stalls the pipeline until the access completes, then presents load data (mdo) to MEMWB for exactly one cycle.
- It replaces the zero-latency memory path with a handshaked one.

Parameters:
- TIMEOUT, 16, max cycles spent in REQ+WAIT before the access aborts with an error (must be >= 2).
- ERR_DATA, 32'hDEADBEEF, value placed on mdo when an access times out.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- resetn  in  1  reset; synchronous, active-low.
- mwmem  in  1  MEM-stage store request.
- mm2reg  in  1  MEM-stage load request.
- mr  in  32  byte address (ALU result).
- mqb  in  32  store data.
- stall  out  1  freeze PC/IFID/IDEXE/EXEMEM; hold MEMWB input.
- mdo  out  32  load data to MEMWB; valid when done=1.
- done  out  1  access complete this cycle.
- err  out  1  access failed this cycle (misaligned or timeout); coincident with done.
- req_valid  out  1  request to memory.
- req_we  out  1  1 = write, 0 = read.
- req_addr  out  30  word address, mr[31:2].
- req_wdata  out  32  write data.
- req_ready  in  1  memory accepts the request.
- rsp_valid  in  1  response/acknowledge (reads and writes).
- rsp_rdata  in  32  read data.

Behaviour:
- Reset values: synchronous on posedge while resetn=0. state=IDLE, req_valid=0, req_we=0, req_addr=0, req_wdata=0, mdo=0, done=0, err=0, timeout counter=0.
- Reset mid-transaction abandons the access; req_valid is low after that edge, and any later rsp_valid is ignored in IDLE.
- Access present: acc = mwmem | mm2reg. If both are set, treat it as a store. Misaligned: mr[1:0] != 0.
- stall is combinational: stall = (state==IDLE & acc) | state==REQ | state==WAIT. stall=0 in DONE and when idle with no access.
- IDLE:
  - acc and aligned -> REQ. Latch req_we=mwmem, req_addr=mr[31:2], req_wdata=mqb; req_valid=1 from the next cycle. Clear the counter.
  - acc and misaligned -> DONE with err=1, mdo=0. No bus request is issued.
- REQ:
  - req_valid held high; req_addr, req_we and req_wdata are stable until accepted.
  - Acceptance is sampled at posedge when req_valid & req_ready.
  - On acceptance, req_valid=0 next cycle and the state moves to WAIT.
  - If rsp_valid is also high in the accept cycle, go straight to DONE and capture rsp_rdata.
- WAIT: on rsp_valid -> DONE. For a read, mdo <= rsp_rdata; for a write, mdo is unchanged.
- Timeout:
  - The counter increments every cycle in REQ or WAIT.
  - When count == TIMEOUT-1 with no completion that cycle: req_valid <= 0, go to DONE with err=1, mdo=ERR_DATA.
  - Completion and timeout in the same cycle: completion wins, err=0.
- DONE:
  - done=1 for exactly one cycle; err as set on entry; stall=0, so MEMWB latches mdo at the end of this cycle.
  - Next state is IDLE unconditionally, so the next instruction's access starts the following cycle and is never double-issued.
- Latency: minimum 3 cycles for an aligned access (IDLE, REQ with same-cycle ready+rsp, DONE).
- Outside DONE: done=0, err=0, mdo holds its last value.
- rsp_valid outside REQ/WAIT is ignored.

Decomposition:
- Shared package (mem_pkg):
  - state encoding IDLE=2'd0, REQ=2'd1, WAIT=2'd2, DONE=2'd3;
  - request struct fields (we, addr[29:0], wdata);
  - ERR_DATA default;
  - timeout counter width = $clog2(TIMEOUT)+1.
- Sub-module: mem_timeout_ctr, a clear/enable counter that asserts expired at TIMEOUT-1.
- FSM, request registers and stall logic stay in mem_access_unit.

Test Plan:
- Load with req_ready=1 and rsp_valid=1 in the first REQ cycle; mr=32'h10, rsp_rdata=32'h40000044 -> req_addr=30'h4, stall high for 2 cycles, DONE cycle shows mdo=32'h40000044, done=1, err=0.
- Store mr=32'h20, mqb=32'h12345678; req_ready delayed 2 cycles, rsp_valid 1 cycle after accept -> req_we=1, req_wdata stable throughout REQ, stall high for 5 cycles, done pulse, err=0.
- Misaligned load mr=32'h13 -> no req_valid ever; next cycle done=1, err=1, mdo=0; stall high for 1 cycle.
- req_ready never asserted, TIMEOUT=16 -> req_valid drops after 16 REQ cycles; done=1, err=1, mdo=32'hDEADBEEF.
- resetn=0 for one cycle while in WAIT -> state IDLE, req_valid=0, stall=0 after that edge; a late rsp_valid is ignored (no done pulse).
- Back-to-back loads mr=32'h0 then 32'h4 -> two separate handshakes, exactly one done pulse each, mdo=32'hA00000AA then 32'h10000011.
